// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one registered ALU between NUM_REQ requesters. One operation is
// accepted at a time under round-robin priority. The operands are held in
// registers that drive the ALU. After the fixed ALU latency the result and
// flags are captured and returned to the winner over a valid/ready handshake.
//
// Ports
//   clk          clock
//   resetn       asynchronous reset, active high
//   req_valid_i  per-requester operation valid
//   req_ready_o  per-requester accept (at most one bit set, IDLE only)
//   req_ctrl_i   4-bit opcode per requester, slice i = requester i
//   req_a_i      operand A per requester
//   req_b_i      operand B per requester
//   rsp_valid_o  one-hot result valid to the owning requester
//   rsp_ready_i  per-requester result accept
//   rsp_y_o      captured result, shared by all requesters
//   rsp_flags_o  captured flags {s,v,n,z,c}
//   busy_o       high whenever the arbiter is not IDLE
//   alu_ctrl_o   registered ALU opcode
//   alu_a_o      registered ALU operand A
//   alu_b_o      registered ALU operand B
//   alu_y_i      ALU result
//   alu_c_i, alu_z_i, alu_n_i, alu_v_i, alu_s_i  ALU flags
`timescale 1ns/1ps

module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [4*NUM_REQ-1:0]     req_ctrl_i,
  input  logic [WIDTH*NUM_REQ-1:0] req_a_i,
  input  logic [WIDTH*NUM_REQ-1:0] req_b_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_y_o,
  output logic [4:0]               rsp_flags_o,
  output logic                     busy_o,
  output logic [3:0]               alu_ctrl_o,
  output logic [WIDTH-1:0]         alu_a_o,
  output logic [WIDTH-1:0]         alu_b_o,
  input  logic [WIDTH-1:0]         alu_y_i,
  input  logic                     alu_c_i,
  input  logic                     alu_z_i,
  input  logic                     alu_n_i,
  input  logic                     alu_v_i,
  input  logic                     alu_s_i
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   grant_q, grant_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [3:0]        aluCtrl_q, aluCtrl_d;
  logic [WIDTH-1:0]  aluA_q, aluA_d;
  logic [WIDTH-1:0]  aluB_q, aluB_d;
  logic [WIDTH-1:0]  rspY_q, rspY_d;
  logic [4:0]        rspFlags_q, rspFlags_d;

  logic              found;
  logic [IDXW-1:0]   winner;
  logic [IDXW:0]     candSum;
  logic [IDXW-1:0]   cand;

  logic [3:0]        ctrlSlice [NUM_REQ];
  logic [WIDTH-1:0]  aSlice    [NUM_REQ];
  logic [WIDTH-1:0]  bSlice    [NUM_REQ];

  // Unpack the flat per-requester buses so the winner can index them directly.
  for (genvar g = 0; g < NUM_REQ; g++) begin : gSlice
    assign ctrlSlice[g] = req_ctrl_i[g*4 +: 4];
    assign aSlice[g]    = req_a_i[g*WIDTH +: WIDTH];
    assign bSlice[g]    = req_b_i[g*WIDTH +: WIDTH];
  end

  // Round-robin search: walk upward from the pointer, wrapping at NUM_REQ,
  // and take the first requester with valid set. The wide sum keeps the
  // wrap correct for non-power-of-two requester counts.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    candSum = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      candSum = {1'b0, ptr_q} + (IDXW+1)'(k);
      if (candSum >= (IDXW+1)'(NUM_REQ)) begin
        candSum = candSum - (IDXW+1)'(NUM_REQ);
      end
      cand = candSum[IDXW-1:0];
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state logic. The latency counter is loaded at accept and counts down
  // through EXEC; the ALU output is sampled only on the cycle it reaches zero,
  // so whatever the ALU drives before then never reaches the response.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    aluCtrl_d  = aluCtrl_q;
    aluA_d     = aluA_q;
    aluB_d     = aluB_q;
    rspY_d     = rspY_q;
    rspFlags_d = rspFlags_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          aluCtrl_d = ctrlSlice[winner];
          aluA_d    = aSlice[winner];
          aluB_d    = bSlice[winner];
          grant_d   = winner;
          cnt_d     = CNTW'(ALU_LAT);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rspY_d     = alu_y_i;
          rspFlags_d = {alu_s_i, alu_v_i, alu_n_i, alu_z_i, alu_c_i};
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i[grant_q]) begin
          ptr_d   = (grant_q == IDXW'(NUM_REQ-1)) ? '0 : grant_q + IDXW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs: ready only while IDLE, valid only while RESP.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (state_q == IDLE && found) begin
      req_ready_o[winner] = 1'b1;
    end
    if (state_q == RESP) begin
      rsp_valid_o[grant_q] = 1'b1;
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      aluCtrl_q  <= '0;
      aluA_q     <= '0;
      aluB_q     <= '0;
      rspY_q     <= '0;
      rspFlags_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      aluCtrl_q  <= aluCtrl_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      rspY_q     <= rspY_d;
      rspFlags_q <= rspFlags_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign alu_ctrl_o  = aluCtrl_q;
  assign alu_a_o     = aluA_q;
  assign alu_b_o     = aluB_q;
  assign rsp_y_o     = rspY_q;
  assign rsp_flags_o = rspFlags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Scoreboard bench for alu_arbiter. Two instances: dut (ALU_LAT=1) and dut3
// (ALU_LAT=3), each in front of a small ALU model. Stimulus pushes the
// hand-computed response into a queue; monitors pop and compare on each
// response handshake, including the cycle rsp_valid rose.
`timescale 1ns/1ps

module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  typedef struct {
    int          owner;
    logic [15:0] y;
    logic [4:0]  f;
    int          rise;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;
  int   multiGrant = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU_LAT=1 instance signals
  logic [1:0]  reqValid, reqReady, rspValid, rspReady;
  logic [7:0]  reqCtrl;
  logic [31:0] reqA, reqB;
  logic [15:0] rspY, aluA, aluB, aluY;
  logic [4:0]  rspFlags;
  logic [3:0]  aluCtrl;
  logic        busy, aluC, aluZ, aluN, aluV, aluS;

  // ALU_LAT=3 instance signals
  logic [1:0]  r3Valid, r3Ready, rsp3Valid, rsp3Ready;
  logic [7:0]  r3Ctrl;
  logic [31:0] r3A, r3B;
  logic [15:0] rsp3Y, alu3A, alu3B, alu3Y;
  logic [4:0]  rsp3Flags;
  logic [3:0]  alu3Ctrl;
  logic        busy3, alu3C, alu3Z, alu3N, alu3V, alu3S;

  exp_t sb[$];
  exp_t sb3[$];

  alu_arbiter #(.NUM_REQ(2), .WIDTH(16), .ALU_LAT(1)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_ctrl_i(reqCtrl),
    .req_a_i(reqA), .req_b_i(reqB),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_y_o(rspY),
    .rsp_flags_o(rspFlags), .busy_o(busy),
    .alu_ctrl_o(aluCtrl), .alu_a_o(aluA), .alu_b_o(aluB), .alu_y_i(aluY),
    .alu_c_i(aluC), .alu_z_i(aluZ), .alu_n_i(aluN), .alu_v_i(aluV), .alu_s_i(aluS)
  );

  alu_arbiter #(.NUM_REQ(2), .WIDTH(16), .ALU_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn),
    .req_valid_i(r3Valid), .req_ready_o(r3Ready), .req_ctrl_i(r3Ctrl),
    .req_a_i(r3A), .req_b_i(r3B),
    .rsp_valid_o(rsp3Valid), .rsp_ready_i(rsp3Ready), .rsp_y_o(rsp3Y),
    .rsp_flags_o(rsp3Flags), .busy_o(busy3),
    .alu_ctrl_o(alu3Ctrl), .alu_a_o(alu3A), .alu_b_o(alu3B), .alu_y_i(alu3Y),
    .alu_c_i(alu3C), .alu_z_i(alu3Z), .alu_n_i(alu3N), .alu_v_i(alu3V), .alu_s_i(alu3S)
  );

  // Behavioural ALU: returns {s,v,n,z,c,y}; undefined opcodes return a byte
  // swizzle with all flags set so pass-through is visible.
  function automatic logic [20:0] aluFn(input logic [3:0] ctrl, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] r;
    logic v, n, z;
    r = '0;
    v = 1'b0;
    case (ctrl)
      OP_ADD: begin
        r = {1'b0, a} + {1'b0, b};
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB: begin
        r = {1'b0, a} - {1'b0, b};
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND: r = {1'b0, a & b};
      OP_OR:  r = {1'b0, a | b};
      OP_XOR: r = {1'b0, a ^ b};
      default: return {5'h1F, a[7:0], b[7:0]};
    endcase
    n = r[15];
    z = (r[15:0] == 16'h0000);
    return {n ^ v, v, n, z, r[16], r[15:0]};
  endfunction

  // One-stage registered ALU for the ALU_LAT=1 instance.
  logic [20:0] alu1Q = '0;
  always @(posedge clk) alu1Q <= aluFn(aluCtrl, aluA, aluB);
  assign aluY = alu1Q[15:0];
  assign {aluS, aluV, aluN, aluZ, aluC} = alu1Q[20:16];

  // Three-stage ALU that drives garbage until its inputs have been stable
  // long enough for the pipeline to hold the real result.
  logic [20:0] p1 = '0, p2 = '0, p3 = '0;
  logic [35:0] lastIn = '0;
  int          stab = 0;
  logic [20:0] alu3Out;
  always @(posedge clk) begin
    p1     <= aluFn(alu3Ctrl, alu3A, alu3B);
    p2     <= p1;
    p3     <= p2;
    lastIn <= {alu3Ctrl, alu3A, alu3B};
    stab   <= ({alu3Ctrl, alu3A, alu3B} == lastIn) ? stab + 1 : 0;
  end
  assign alu3Out = (stab >= 2) ? p3 : {5'h13, 16'hDEAD};
  assign alu3Y = alu3Out[15:0];
  assign {alu3S, alu3V, alu3N, alu3Z, alu3C} = alu3Out[20:16];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic reportTimeout(input string name);
    checkCount++;
    $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor for the ALU_LAT=1 instance; also counts any multi-bit grant.
  logic [1:0] prevValid = '0;
  int         riseCyc = 0;
  exp_t       e;
  always @(negedge clk) begin
    if ((reqReady & (reqReady - 2'd1)) != 2'b00) multiGrant++;
    if ((r3Ready & (r3Ready - 2'd1)) != 2'b00) multiGrant++;
    if (resetn) begin
      prevValid = '0;
    end else begin
      if (rspValid != 2'b00 && prevValid == 2'b00) riseCyc = cyc;
      prevValid = rspValid;
      if ((rspValid & rspReady) != 2'b00) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 64'(rspValid), 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_owner", 64'(rspValid), 64'(2'b01 << e.owner));
          checkOutput("rsp_y", 64'(rspY), 64'(e.y));
          checkOutput("rsp_flags", 64'(rspFlags), 64'(e.f));
          checkOutput("rsp_rise_cycle", 64'(riseCyc), 64'(e.rise));
        end
      end
    end
  end

  // Monitor for the ALU_LAT=3 instance.
  logic [1:0] prev3Valid = '0;
  int         rise3Cyc = 0;
  exp_t       e3;
  always @(negedge clk) begin
    if (resetn) begin
      prev3Valid = '0;
    end else begin
      if (rsp3Valid != 2'b00 && prev3Valid == 2'b00) rise3Cyc = cyc;
      prev3Valid = rsp3Valid;
      if ((rsp3Valid & rsp3Ready) != 2'b00) begin
        if (sb3.size() == 0) begin
          checkOutput("lat3_unexpected_rsp", 64'(rsp3Valid), 64'd0);
        end else begin
          e3 = sb3.pop_front();
          checkOutput("lat3_owner", 64'(rsp3Valid), 64'(2'b01 << e3.owner));
          checkOutput("lat3_y", 64'(rsp3Y), 64'(e3.y));
          checkOutput("lat3_flags", 64'(rsp3Flags), 64'(e3.f));
          checkOutput("lat3_rise_cycle", 64'(rise3Cyc), 64'(e3.rise));
        end
      end
    end
  end

  task automatic waitDrain();
    bit done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1;
    end
    if (!done) reportTimeout("drain");
  endtask

  // Issue one operation on the ALU_LAT=1 instance, expecting the response
  // three cycles after accept; operands are scrambled right after accept.
  task automatic applyStimulus(input int idx, input logic [3:0] ctrl, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] expY,
                               input logic [4:0] expF);
    bit got = 0;
    int acc;
    reqCtrl[idx*4 +: 4]  = ctrl;
    reqA[idx*16 +: 16]   = a;
    reqB[idx*16 +: 16]   = b;
    reqValid[idx]        = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (reqReady[idx]) got = 1;
    end
    if (!got) begin
      reportTimeout("accept");
      reqValid[idx] = 1'b0;
      return;
    end
    acc = cyc;
    sb.push_back('{idx, expY, expF, acc + 3});
    @(posedge clk); #1;
    reqValid[idx]       = 1'b0;
    reqCtrl[idx*4 +: 4] = ~ctrl;
    reqA[idx*16 +: 16]  = ~a;
    reqB[idx*16 +: 16]  = ~b;
    @(negedge clk);
    checkOutput("alu_inputs", 64'({aluCtrl, aluA, aluB}), 64'({ctrl, a, b}));
    waitDrain();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a0, acc, sawRsp;
    bit got;
    resetn    = 1'b0;
    reqValid  = '0; reqCtrl = '0; reqA = '0; reqB = '0; rspReady = 2'b11;
    r3Valid   = '0; r3Ctrl  = '0; r3A  = '0; r3B  = '0; rsp3Ready = 2'b11;
    #2 resetn = 1'b1;
    #2;
    checkOutput("reset_outputs",
                {2'b00, reqReady, rspValid, rspY, rspFlags, busy, aluCtrl, aluA, aluB}, 64'd0);
    checkOutput("reset_outputs_lat3",
                {2'b00, r3Ready, rsp3Valid, rsp3Y, rsp3Flags, busy3, alu3Ctrl, alu3A, alu3B}, 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;

    // Basic ADD and the flags path through SUB.
    applyStimulus(0, OP_ADD, 16'h0003, 16'h0004, 16'h0007, 5'h00);
    applyStimulus(1, OP_SUB, 16'h0003, 16'h0004, 16'hFFFF, 5'h15);

    // Contention: both requesters held valid, grants must alternate.
    a0 = cyc;
    reqCtrl = {OP_AND, OP_ADD};
    reqA    = {16'hF00F, 16'h0001};
    reqB    = {16'hF0F0, 16'h0001};
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sb.push_back('{0, 16'h0002, 5'h00, a0 + 3 + 4*k});
      else            sb.push_back('{1, 16'hF000, 5'h14, a0 + 3 + 4*k});
    end
    reqValid = 2'b11;
    while (cyc < a0 + 16) begin
      @(posedge clk); #1;
    end
    reqValid = 2'b00;
    waitDrain();
    @(posedge clk); #1;

    // Backpressure: owner holds rsp_ready low; the other requester's ready
    // bit and valid request must both be ignored.
    rspReady      = 2'b10;
    reqCtrl[3:0]  = OP_XOR;
    reqA[15:0]    = 16'h5A5A;
    reqB[15:0]    = 16'hA5A5;
    reqValid[0]   = 1'b1;
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (reqReady[0]) got = 1;
    end
    if (!got) reportTimeout("bp_accept");
    acc = cyc;
    sb.push_back('{0, 16'hFFFF, 5'h14, acc + 3});
    @(posedge clk); #1;
    reqValid[0]   = 1'b0;
    reqCtrl[7:4]  = OP_OR;
    reqA[31:16]   = 16'h0000;
    reqB[31:16]   = 16'h0000;
    reqValid[1]   = 1'b1;
    while (cyc < acc + 3) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_hold", 64'({rspValid, rspY, rspFlags, reqReady, busy}),
                  64'({2'b01, 16'hFFFF, 5'h14, 2'b00, 1'b1}));
    end
    @(posedge clk); #1;
    rspReady = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp_release_idle", 64'({busy, reqReady}), 64'({1'b0, 2'b10}));
    sb.push_back('{1, 16'h0000, 5'h02, cyc + 3});
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    waitDrain();
    @(posedge clk); #1;

    // Undefined opcode passes straight through; leaves the pointer at 1.
    applyStimulus(0, 4'hF, 16'h1234, 16'h5678, 16'h3478, 5'h1F);

    // Reset during EXEC discards the operation and clears the pointer.
    reqCtrl[7:4] = OP_ADD;
    reqA[31:16]  = 16'h7FFF;
    reqB[31:16]  = 16'h7FFF;
    reqValid[1]  = 1'b1;
    @(negedge clk);
    checkOutput("grant_from_ptr1", 64'(reqReady), 64'(2'b10));
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    #2 resetn = 1'b1;
    #1;
    checkOutput("async_reset_outputs",
                {2'b00, reqReady, rspValid, rspY, rspFlags, busy, aluCtrl, aluA, aluB}, 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    sawRsp = 0;
    repeat (6) begin
      @(negedge clk);
      if (rspValid != 2'b00) sawRsp++;
    end
    checkOutput("no_rsp_after_reset", 64'(sawRsp), 64'd0);
    @(posedge clk); #1;
    reqCtrl  = {OP_XOR, OP_ADD};
    reqA     = {16'h1111, 16'h8000};
    reqB     = {16'h2222, 16'h8000};
    reqValid = 2'b11;
    @(negedge clk);
    checkOutput("first_grant_after_reset", 64'(reqReady), 64'(2'b01));
    sb.push_back('{0, 16'h0000, 5'h1B, cyc + 3});
    #1 reqValid[1] = 1'b0;
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    waitDrain();
    @(posedge clk); #1;

    // ALU_LAT=3: the model ALU drives garbage until the capture cycle.
    r3Ctrl[3:0] = OP_ADD;
    r3A[15:0]   = 16'h4000;
    r3B[15:0]   = 16'h4000;
    r3Valid[0]  = 1'b1;
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (r3Ready[0]) got = 1;
    end
    if (!got) reportTimeout("lat3_accept");
    sb3.push_back('{0, 16'h8000, 5'h0C, cyc + 5});
    @(posedge clk); #1;
    r3Valid[0] = 1'b0;
    r3A[15:0]  = 16'hFFFF;
    got = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (sb3.size() == 0) got = 1;
    end
    if (!got) reportTimeout("lat3_drain");

    checkOutput("ready_onehot", 64'(multiGrant), 64'd0);
    checkOutput("scoreboard_empty", 64'(sb.size() + sb3.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
